egg_timer_ctrl: RTL and testbench

//  Control and time-entry front end for the egg-timer downcounter: turns debounced button pulses into
//  a BCD MM:SS set value, drives the counter's load/enable/enable_timer inputs, watches its digits
//  and raises the alarm at 00:00. Runs on the fast system clock; the counter itself runs on pulse_1Hz.

---
 rtl/egg_timer_ctrl_if.sv | 34 +++
 rtl/egg_timer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/egg_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// egg_timer_ctrl_if
// Connection between the egg-timer controller and the BCD MM:SS downcounter.
// Every nibble-packed bus below is {min_tens, min_ones, sec_tens, sec_ones}.
//   cnt_digits    counter -> controller  current counter digits
//   load_digits   controller -> counter  set value presented to the load inputs
//   load          controller -> counter  load strobe
//   enable        controller -> counter  count enable
//   enable_timer  controller -> counter  run/clear (0 clears on the counter's next edge)
// Modports: master = controller side, slave = counter side.
// ---------------------------------------------------------------------------
interface egg_timer_ctrl_if;
  logic [15:0] cnt_digits;
  logic [15:0] load_digits;
  logic        load;
  logic        enable;
  logic        enable_timer;

  modport master (
    input  cnt_digits,
    output load_digits,
    output load,
    output enable,
    output enable_timer
  );

  modport slave (
    output cnt_digits,
    input  load_digits,
    input  load,
    input  enable,
    input  enable_timer
  );
endinterface

// File: rtl/egg_timer_ctrl.sv
// ---------------------------------------------------------------------------
// egg_timer_ctrl
// Control and time-entry front end for the egg-timer downcounter. It turns
// debounced one-clock button pulses into a BCD MM:SS set value, sequences the
// counter through load / run / pause, watches the counter digits and raises
// the alarm at 00:00. Everything runs on the fast system clock. tick_1hz marks
// the system-clock cycle whose edge also clocks the counter.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   tick_1hz             one-clk pulse coincident with the counter's clock edge
//   btn_up/down          increment / decrement the digit under the cursor
//   btn_left/right       move the cursor to a more / less significant digit
//   btn_start            start, pause, resume
//   btn_clear            abort to SET; the set value is kept
//   cnt_bus              counter connection (cnt_digits in; load_digits, load,
//                        enable, enable_timer out)
//   cursor               selected digit: 0=sec_ones 1=sec_tens 2=min_ones 3=min_tens
//   state_o              SET=0 LOAD=1 RUN=2 PAUSE=3 DONE=4, for the display mux
//   alarm, alarm_blink   high in DONE; blink toggles on each tick in DONE
// ---------------------------------------------------------------------------
module egg_timer_ctrl #(
  parameter int MAX_MIN_TENS = 9,
  parameter int ALARM_SECS   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_1hz,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_start,
  input  logic                   btn_clear,
  egg_timer_ctrl_if.master       cnt_bus,
  output logic [1:0]             cursor,
  output logic [2:0]             state_o,
  output logic                   alarm,
  output logic                   alarm_blink
);

  typedef enum logic [2:0] {
    SET   = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);
  // Last tick count before the alarm times out (the counter starts at 0 on entry).
  localparam logic [7:0] ALARM_LAST   = 8'(ALARM_SECS - 1);

  state_t      state, state_next;
  logic [15:0] digits, digits_next;
  logic [1:0]  cursor_next;
  logic        seen_nz, seen_nz_next;
  logic [7:0]  tick_cnt, tick_cnt_next;
  logic        blink_next;
  logic        load_q, enable_q, enable_timer_q;
  logic [3:0]  sel_digit;
  logic [3:0]  sel_max;
  logic        any_btn;

  // Highest legal value of each digit position; every digit wraps between 0 and this.
  function automatic logic [3:0] digit_max(input logic [1:0] pos);
    case (pos)
      2'd1:    digit_max = 4'd5;
      2'd3:    digit_max = MIN_TENS_MAX;
      default: digit_max = 4'd9;
    endcase
  endfunction

  assign cnt_bus.load_digits  = digits;
  assign cnt_bus.load         = load_q;
  assign cnt_bus.enable       = enable_q;
  assign cnt_bus.enable_timer = enable_timer_q;
  assign state_o              = state;

  // Next-state and next-value logic. Within a single clock only the
  // highest-priority button acts (clear > start > up > down > left > right).
  // In DONE any button returns to SET. The alarm tick counter keeps counting
  // in the same cycle, but the button transition wins. seen_nz stops a counter
  // that still reads 00:00 from raising the alarm straight after the load: it
  // must show a non-zero value in RUN before a zero counts as finished.
  always_comb begin
    state_next    = state;
    digits_next   = digits;
    cursor_next   = cursor;
    seen_nz_next  = seen_nz;
    tick_cnt_next = 8'd0;
    blink_next    = 1'b0;
    sel_digit     = digits[{cursor, 2'b00} +: 4];
    sel_max       = digit_max(cursor);
    any_btn       = btn_up | btn_down | btn_left | btn_right | btn_start | btn_clear;

    case (state)
      SET: begin
        if (btn_clear) begin
          state_next = SET;
        end else if (btn_start) begin
          if (digits != 16'h0000) state_next = LOAD;
        end else if (btn_up) begin
          digits_next[{cursor, 2'b00} +: 4] = (sel_digit >= sel_max) ? 4'd0 : sel_digit + 4'd1;
        end else if (btn_down) begin
          digits_next[{cursor, 2'b00} +: 4] = (sel_digit == 4'd0) ? sel_max : sel_digit - 4'd1;
        end else if (btn_left) begin
          cursor_next = cursor + 2'd1;
        end else if (btn_right) begin
          cursor_next = cursor - 2'd1;
        end
      end
      LOAD: begin
        seen_nz_next = 1'b0;
        if (btn_clear)     state_next = SET;
        else if (tick_1hz) state_next = RUN;
      end
      RUN: begin
        if (cnt_bus.cnt_digits != 16'h0000) seen_nz_next = 1'b1;
        if (btn_clear)                                         state_next = SET;
        else if (btn_start)                                    state_next = PAUSE;
        else if (cnt_bus.cnt_digits == 16'h0000 && seen_nz)    state_next = DONE;
      end
      PAUSE: begin
        if (btn_clear)      state_next = SET;
        else if (btn_start) state_next = RUN;
      end
      DONE: begin
        tick_cnt_next = tick_1hz ? tick_cnt + 8'd1 : tick_cnt;
        if (any_btn)                                 state_next = SET;
        else if (tick_1hz && tick_cnt == ALARM_LAST) state_next = SET;
      end
      default: state_next = SET;
    endcase

    if (state_next == DONE) begin
      blink_next = (state == DONE && tick_1hz) ? ~alarm_blink : alarm_blink;
    end
  end

  // State and output registers. The counter controls are registered decodes of
  // the next state, so they change on the same edge as state_o. A reset
  // discards the set value along with everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SET;
      digits         <= 16'h0000;
      cursor         <= 2'd0;
      seen_nz        <= 1'b0;
      tick_cnt       <= 8'd0;
      load_q         <= 1'b0;
      enable_q       <= 1'b0;
      enable_timer_q <= 1'b0;
      alarm          <= 1'b0;
      alarm_blink    <= 1'b0;
    end else begin
      state          <= state_next;
      digits         <= digits_next;
      cursor         <= cursor_next;
      seen_nz        <= seen_nz_next;
      tick_cnt       <= tick_cnt_next;
      load_q         <= (state_next == LOAD);
      enable_q       <= (state_next == RUN);
      enable_timer_q <= (state_next != SET);
      alarm          <= (state_next == DONE);
      alarm_blink    <= blink_next;
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_egg_timer_ctrl
// Directed bench for egg_timer_ctrl. A small behavioural BCD downcounter
// stands in for the real counter and is clocked on tick_1hz cycles. Expected
// values are queued as each stimulus step is driven. They are then popped and
// compared once the step's clock edge has produced the DUT outputs.
// ---------------------------------------------------------------------------
module tb_egg_timer_ctrl;

  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_RIGHT = 6'b000001;
  localparam logic [5:0] B_LEFT  = 6'b000010;
  localparam logic [5:0] B_DOWN  = 6'b000100;
  localparam logic [5:0] B_UP    = 6'b001000;
  localparam logic [5:0] B_START = 6'b010000;
  localparam logic [5:0] B_CLEAR = 6'b100000;

  typedef enum logic [3:0] {
    S_DIGITS, S_CURSOR, S_STATE, S_LOAD, S_ENABLE, S_ENTIMER, S_ALARM, S_BLINK, S_CNT
  } sel_t;

  typedef struct {
    sel_t        sel;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_start = 1'b0, btn_clear = 1'b0;
  logic [1:0]  cursor;
  logic [2:0]  state_o;
  logic        alarm, alarm_blink;
  logic [15:0] cnt_model = 16'h0000;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  egg_timer_ctrl_if bus();

  egg_timer_ctrl #(.MAX_MIN_TENS(9), .ALARM_SECS(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .cnt_bus     (bus),
    .cursor      (cursor),
    .state_o     (state_o),
    .alarm       (alarm),
    .alarm_blink (alarm_blink)
  );

  always #5 clk = ~clk;

  assign bus.cnt_digits = cnt_model;

  // One BCD MM:SS step down. The counter stops at 00:00.
  function automatic logic [15:0] bcdDec(input logic [15:0] v);
    logic [3:0] s1, s10, m1, m10;
    {m10, m1, s10, s1} = v;
    if (v == 16'h0000) return v;
    if (s1 != 4'd0) s1 = s1 - 4'd1;
    else begin
      s1 = 4'd9;
      if (s10 != 4'd0) s10 = s10 - 4'd1;
      else begin
        s10 = 4'd5;
        if (m1 != 4'd0) m1 = m1 - 4'd1;
        else begin
          m1 = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // Behavioural downcounter, clocked by the same edge that tick_1hz marks.
  always @(posedge clk) begin
    if (tick_1hz) begin
      if (!bus.enable_timer) cnt_model <= 16'h0000;
      else if (bus.load)     cnt_model <= bus.load_digits;
      else if (bus.enable)   cnt_model <= bcdDec(cnt_model);
    end
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] observe(input sel_t s);
    case (s)
      S_DIGITS:  return bus.load_digits;
      S_CURSOR:  return {14'd0, cursor};
      S_STATE:   return {13'd0, state_o};
      S_LOAD:    return {15'd0, bus.load};
      S_ENABLE:  return {15'd0, bus.enable};
      S_ENTIMER: return {15'd0, bus.enable_timer};
      S_ALARM:   return {15'd0, alarm};
      S_BLINK:   return {15'd0, alarm_blink};
      default:   return cnt_model;
    endcase
  endfunction

  task automatic expectVal(input sel_t s, input logic [15:0] v, input string tag);
    exp_t e;
    e.sel = s;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive one clock's worth of buttons/tick from a falling edge. Inputs are
  // released at the next falling edge, after the rising edge has sampled them.
  task automatic applyStimulus(input logic [5:0] btns, input logic tk);
    {btn_clear, btn_start, btn_up, btn_down, btn_left, btn_right} = btns;
    tick_1hz = tk;
    @(negedge clk);
    {btn_clear, btn_start, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    tick_1hz = 1'b0;
  endtask

  task automatic repeatStimulus(input logic [5:0] btns, input int n);
    for (int i = 0; i < n; i++) applyStimulus(btns, 1'b0);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    // Reset
    @(negedge clk);
    reset = 1'b1;
    repeat (2) applyStimulus(B_NONE, 1'b0);
    reset = 1'b0;
    expectVal(S_STATE, 16'd0, "reset_state");
    expectVal(S_DIGITS, 16'h0000, "reset_digits");
    expectVal(S_CURSOR, 16'd0, "reset_cursor");
    expectVal(S_LOAD, 16'd0, "reset_load");
    expectVal(S_ENABLE, 16'd0, "reset_enable");
    expectVal(S_ENTIMER, 16'd0, "reset_entimer");
    expectVal(S_ALARM, 16'd0, "reset_alarm");
    expectVal(S_BLINK, 16'd0, "reset_blink");
    checkOutput();

    // Up and down together: up has priority
    applyStimulus(B_UP | B_DOWN, 1'b0);
    expectVal(S_DIGITS, 16'h0001, "prio_up_over_down");
    checkOutput();
    reset = 1'b1;
    applyStimulus(B_NONE, 1'b0);
    reset = 1'b0;
    expectVal(S_DIGITS, 16'h0000, "reset_clears_digits");
    checkOutput();

    // Basic entry: up x3, left, up x2
    repeatStimulus(B_UP, 3);
    applyStimulus(B_LEFT, 1'b0);
    repeatStimulus(B_UP, 2);
    expectVal(S_DIGITS, 16'h0023, "entry_digits");
    expectVal(S_CURSOR, 16'd1, "entry_cursor");
    checkOutput();

    // Digit wrap boundaries
    repeatStimulus(B_UP, 3);
    expectVal(S_DIGITS, 16'h0053, "sec_tens_at_5");
    checkOutput();
    applyStimulus(B_UP, 1'b0);
    expectVal(S_DIGITS, 16'h0003, "sec_tens_wrap_up");
    checkOutput();
    applyStimulus(B_RIGHT, 1'b0);
    expectVal(S_CURSOR, 16'd0, "cursor_right");
    checkOutput();
    repeatStimulus(B_DOWN, 3);
    applyStimulus(B_DOWN, 1'b0);
    expectVal(S_DIGITS, 16'h0009, "sec_ones_wrap_down");
    checkOutput();
    applyStimulus(B_RIGHT, 1'b0);
    expectVal(S_CURSOR, 16'd3, "cursor_right_wrap");
    checkOutput();
    repeatStimulus(B_UP, 9);
    expectVal(S_DIGITS, 16'h9009, "min_tens_at_max");
    checkOutput();
    applyStimulus(B_UP, 1'b0);
    expectVal(S_DIGITS, 16'h0009, "min_tens_wrap_up");
    checkOutput();
    applyStimulus(B_LEFT, 1'b0);
    expectVal(S_CURSOR, 16'd0, "cursor_left_wrap");
    checkOutput();

    // Start at 00:00 is ignored
    repeatStimulus(B_DOWN, 9);
    applyStimulus(B_START, 1'b0);
    expectVal(S_STATE, 16'd0, "start_at_zero_state");
    expectVal(S_LOAD, 16'd0, "start_at_zero_load");
    checkOutput();

    // 00:03 countdown to DONE
    repeatStimulus(B_UP, 3);
    applyStimulus(B_START, 1'b0);
    expectVal(S_STATE, 16'd1, "load_state");
    expectVal(S_LOAD, 16'd1, "load_strobe");
    expectVal(S_ENTIMER, 16'd1, "load_entimer");
    expectVal(S_ENABLE, 16'd0, "load_enable");
    checkOutput();
    repeatStimulus(B_NONE, 2);
    expectVal(S_STATE, 16'd1, "load_held");
    expectVal(S_LOAD, 16'd1, "load_held_strobe");
    checkOutput();
    applyStimulus(B_NONE, 1'b1);
    expectVal(S_STATE, 16'd2, "run_state");
    expectVal(S_LOAD, 16'd0, "run_load");
    expectVal(S_ENABLE, 16'd1, "run_enable");
    expectVal(S_CNT, 16'h0003, "counter_loaded");
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(B_NONE, 1'b0);
      applyStimulus(B_NONE, 1'b1);
    end
    expectVal(S_CNT, 16'h0000, "counter_zero");
    expectVal(S_STATE, 16'd2, "still_run_at_zero");
    expectVal(S_ALARM, 16'd0, "no_alarm_yet");
    checkOutput();
    applyStimulus(B_NONE, 1'b0);
    expectVal(S_STATE, 16'd4, "done_state");
    expectVal(S_ALARM, 16'd1, "done_alarm");
    expectVal(S_ENABLE, 16'd0, "done_enable");
    expectVal(S_ENTIMER, 16'd1, "done_entimer");
    checkOutput();

    // Alarm times out after 10 ticks, blinking on each
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(B_NONE, 1'b1);
      if (k < 10) begin
        expectVal(S_STATE, 16'd4, $sformatf("alarm_state_t%0d", k));
        expectVal(S_BLINK, 16'(k % 2), $sformatf("blink_t%0d", k));
      end else begin
        expectVal(S_STATE, 16'd0, "alarm_timeout_state");
        expectVal(S_BLINK, 16'd0, "alarm_timeout_blink");
        expectVal(S_ALARM, 16'd0, "alarm_timeout_alarm");
        expectVal(S_ENTIMER, 16'd0, "alarm_timeout_entimer");
      end
      checkOutput();
      applyStimulus(B_NONE, 1'b0);
    end
    expectVal(S_DIGITS, 16'h0003, "set_value_kept");
    checkOutput();

    // Pause and resume at 00:10
    repeatStimulus(B_DOWN, 3);
    applyStimulus(B_LEFT, 1'b0);
    applyStimulus(B_UP, 1'b0);
    expectVal(S_DIGITS, 16'h0010, "set_0010");
    checkOutput();
    applyStimulus(B_START, 1'b0);
    applyStimulus(B_NONE, 1'b1);
    expectVal(S_STATE, 16'd2, "run_0010");
    expectVal(S_CNT, 16'h0010, "loaded_0010");
    checkOutput();
    applyStimulus(B_NONE, 1'b0);
    applyStimulus(B_START, 1'b0);
    expectVal(S_STATE, 16'd3, "pause_state");
    expectVal(S_ENABLE, 16'd0, "pause_enable");
    expectVal(S_ENTIMER, 16'd1, "pause_entimer");
    checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(B_NONE, 1'b1);
      applyStimulus(B_NONE, 1'b0);
    end
    expectVal(S_CNT, 16'h0010, "paused_frozen");
    expectVal(S_STATE, 16'd3, "paused_held");
    checkOutput();
    applyStimulus(B_START, 1'b0);
    expectVal(S_STATE, 16'd2, "resume_state");
    expectVal(S_ENABLE, 16'd1, "resume_enable");
    checkOutput();
    applyStimulus(B_NONE, 1'b1);
    expectVal(S_CNT, 16'h0009, "resumed_count");
    checkOutput();

    // Clear and start together in RUN: clear wins
    applyStimulus(B_CLEAR | B_START, 1'b0);
    expectVal(S_STATE, 16'd0, "clear_prio_state");
    expectVal(S_ENTIMER, 16'd0, "clear_prio_entimer");
    expectVal(S_DIGITS, 16'h0010, "clear_keeps_digits");
    checkOutput();

    // Reset during LOAD
    applyStimulus(B_START, 1'b0);
    expectVal(S_STATE, 16'd1, "reload_state");
    checkOutput();
    reset = 1'b1;
    applyStimulus(B_NONE, 1'b0);
    reset = 1'b0;
    expectVal(S_STATE, 16'd0, "reset_in_load_state");
    expectVal(S_LOAD, 16'd0, "reset_in_load_load");
    expectVal(S_ENTIMER, 16'd0, "reset_in_load_entimer");
    expectVal(S_DIGITS, 16'h0000, "reset_in_load_digits");
    expectVal(S_CURSOR, 16'd0, "reset_in_load_cursor");
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
